id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection and stall/flush control. It captures decoded operands and control from the decode stage. It supplies id_ex_rs1/id_ex_rs2 and the operand data directly to the EX-stage forwarding unit and ALU. It inserts bubbles for load-use hazards and taken-branch flushes, and freezes on global memory stalls.

Parameters:
XLEN, 32, datapath width
ALU_OP_W, 4, ALU operation code width
CNT_W, 16, width of saturating performance counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  decode stage holds a valid instruction
id_rs1, id_rs2, id_rd  input  5 each  register indices from decode
id_use_rs1, id_use_rs2  input  1 each  instruction actually reads rs1/rs2
id_rs1_data, id_rs2_data  input  XLEN each  register file read data
id_imm, id_pc  input  XLEN each  immediate and PC
id_alu_op  input  ALU_OP_W  ALU operation
id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  input  1 each  control
ex_flush  input  1  branch/jump taken, resolved in EX
mem_stall  input  1  global freeze from data memory
pc_write  output  1  PC may advance
if_id_write  output  1  IF/ID register may load
id_ex_valid  output  1  EX holds a valid instruction
id_ex_rs1, id_ex_rs2, id_ex_rd  output  5 each  registered indices, to forwarding unit
id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc  output  XLEN each  registered data
id_ex_alu_op  output  ALU_OP_W  registered ALU op
id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_branch  output  1 each  registered control
load_use_cnt, flush_cnt  output  CNT_W each  saturating bubble counters

Behaviour:
- Reset (rst_n low, asynchronous): all id_ex_* outputs are 0, id_ex_valid is 0, and both counters are 0. pc_write and if_id_write are combinational and read 1 while in reset.
- load_use (combinational) = id_ex_valid & id_ex_mem_read & (id_ex_rd != 0) & id_valid & ((id_use_rs1 & id_rs1 == id_ex_rd) | (id_use_rs2 & id_rs2 == id_ex_rd)).
- pc_write = if_id_write = !(mem_stall | (load_use & !ex_flush)).
- Register update priority at each rising edge:
  1. mem_stall = 1: hold all registers unchanged, including counters. ex_flush is ignored; EX keeps it asserted until the stall clears.
  2. ex_flush = 1: load a bubble (id_ex_valid = 0, all control bits = 0, id_ex_rd = 0). Data fields are don't-care but are also driven to 0. flush_cnt increments.
  3. load_use = 1: load a bubble as above. load_use_cnt increments. IF/ID and PC hold, so the same decode instruction is re-presented next cycle. The hazard then clears because the load has moved to MEM.
  4. Otherwise: capture all id_* inputs. id_ex_valid = id_valid. If id_valid = 0, control bits are forced to 0.
- A bubble never carries reg_write, mem_read or mem_write = 1. This guarantees the forwarding unit never matches a bubble.
- Latency: one cycle from decode input to id_ex_* output. A load-use hazard costs exactly one bubble.
- Back-to-back loads feeding a dependent instruction produce one bubble per dependent pair, never two for the same pair.
- Counters saturate at 2^CNT_W - 1 and do not wrap.
- Reset asserted mid-stall or mid-flush immediately clears all state. The first edge after deassertion behaves per the normal priority rules.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - ALU_OP_W and the ALU op encodings
  - forwarding select constants FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10
  - a control-bundle struct with a NOP/bubble constant
- One natural sub-module: load_use_detector, purely combinational. It produces load_use from the ID/EX and decode fields, and is instantiated once.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with id_valid = 1 and reg_write = 1 -> all id_ex_* outputs are 0 immediately (no clock needed), and both counters are 0.
- Load-use: lw x5 in EX (mem_read = 1, rd = 5), then decode add with rs1 = 5 -> pc_write = 0 and if_id_write = 0 for 1 cycle. The next EX holds a bubble (valid = 0, reg_write = 0) and load_use_cnt = 1. The add enters EX on the following cycle with id_ex_rs1 = 5.
- False hazard: lw x0 or lw x5, then decode an instruction with id_use_rs2 = 0 and rs2 = 5 -> no stall, load_use_cnt unchanged.
- Flush and load-use in the same cycle: ex_flush = 1 with load_use = 1 -> bubble inserted, pc_write = 1, flush_cnt = 1, load_use_cnt = 0.
- mem_stall for 3 cycles with ex_flush = 1 -> outputs frozen, counters frozen, pc_write = 0. On the first edge after mem_stall drops, bubble inserted and flush_cnt increments by 1.
- Saturation: CNT_W = 4, force 20 consecutive flushes -> flush_cnt reaches 15 and holds at 15.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline types: ALU ops, forwarding selects, control bundle
package riscv_pipe_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'h9;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic alu_src;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

  // A bubble must never write anything, so the forwarding unit can never match it.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detector.sv
// rtl/load_use_detector.sv - flags a decode instruction that needs the result of a load now in EX
module load_use_detector (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 never carries a loaded value, so a load into it is never a hazard.
  assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, flush and memory-stall freeze
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [4:0]          id_rd,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_alu_src,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                id_branch,
  input  logic                ex_flush,
  input  logic                mem_stall,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                id_ex_valid,
  output logic [4:0]          id_ex_rs1,
  output logic [4:0]          id_ex_rs2,
  output logic [4:0]          id_ex_rd,
  output logic [XLEN-1:0]     id_ex_rs1_data,
  output logic [XLEN-1:0]     id_ex_rs2_data,
  output logic [XLEN-1:0]     id_ex_imm,
  output logic [XLEN-1:0]     id_ex_pc,
  output logic [ALU_OP_W-1:0] id_ex_alu_op,
  output logic                id_ex_alu_src,
  output logic                id_ex_reg_write,
  output logic                id_ex_mem_read,
  output logic                id_ex_mem_write,
  output logic                id_ex_mem_to_reg,
  output logic                id_ex_branch,
  output logic [CNT_W-1:0]    load_use_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  load_use;
  logic  advance;

  assign id_ctrl = '{alu_src:    id_alu_src,
                     reg_write:  id_reg_write,
                     mem_read:   id_mem_read,
                     mem_write:  id_mem_write,
                     mem_to_reg: id_mem_to_reg,
                     branch:     id_branch};

  load_use_detector u_load_use_detector (
    .ex_valid    (id_ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (id_ex_rd),
    .id_valid    (id_valid),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .load_use    (load_use)
  );

  // A flush discards the stalled decode instruction anyway, so it overrides the load-use hold.
  assign advance     = !(mem_stall || (load_use && !ex_flush));
  assign pc_write    = !rst_n || advance;
  assign if_id_write = pc_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_valid    <= 1'b0;
      id_ex_rs1      <= '0;
      id_ex_rs2      <= '0;
      id_ex_rd       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_pc       <= '0;
      id_ex_alu_op   <= '0;
      ex_ctrl        <= CTRL_NOP;
      load_use_cnt   <= '0;
      flush_cnt      <= '0;
    end else if (mem_stall) begin
      // Whole stage frozen; EX keeps any pending flush asserted until the stall clears.
    end else if (ex_flush || load_use) begin
      id_ex_valid    <= 1'b0;
      id_ex_rs1      <= '0;
      id_ex_rs2      <= '0;
      id_ex_rd       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_pc       <= '0;
      id_ex_alu_op   <= '0;
      ex_ctrl        <= CTRL_NOP;
      if (ex_flush) begin
        if (!(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      end else begin
        if (!(&load_use_cnt)) load_use_cnt <= load_use_cnt + 1'b1;
      end
    end else begin
      id_ex_valid    <= id_valid;
      id_ex_rs1      <= id_rs1;
      id_ex_rs2      <= id_rs2;
      id_ex_rd       <= id_rd;
      id_ex_rs1_data <= id_rs1_data;
      id_ex_rs2_data <= id_rs2_data;
      id_ex_imm      <= id_imm;
      id_ex_pc       <= id_pc;
      id_ex_alu_op   <= id_alu_op;
      ex_ctrl        <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  assign id_ex_alu_src    = ex_ctrl.alu_src;
  assign id_ex_reg_write  = ex_ctrl.reg_write;
  assign id_ex_mem_read   = ex_ctrl.mem_read;
  assign id_ex_mem_write  = ex_ctrl.mem_write;
  assign id_ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign id_ex_branch     = ex_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;
  localparam int CNT_W    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_valid;
  logic [4:0]          id_rs1, id_rs2, id_rd;
  logic                id_use_rs1, id_use_rs2;
  logic [XLEN-1:0]     id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic                ex_flush, mem_stall;
  logic                pc_write, if_id_write, id_ex_valid;
  logic [4:0]          id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [XLEN-1:0]     id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc;
  logic [ALU_OP_W-1:0] id_ex_alu_op;
  logic                id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic                id_ex_mem_to_reg, id_ex_branch;
  logic [CNT_W-1:0]    load_use_cnt, flush_cnt;

  id_ex_stage #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .ex_flush(ex_flush), .mem_stall(mem_stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_valid(id_ex_valid),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc), .id_ex_alu_op(id_ex_alu_op),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
    .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_branch(id_ex_branch),
    .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic        v;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        rw;
    logic        mr;
    logic [31:0] data;
    int          lu;
    int          fl;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic pw_s, ifw_s;

  function automatic logic [31:0] dpat(input int tag);
    return {16'hD00D, 16'(tag)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic u1, input logic u2,
                     input logic mr, input logic rw, input logic fl, input logic st,
                     input int tag);
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2;
    id_mem_read = mr; id_mem_to_reg = mr; id_reg_write = rw;
    id_mem_write = 1'b0; id_branch = 1'b0; id_alu_src = 1'b1;
    id_alu_op = 4'(tag);
    id_rs1_data = dpat(tag); id_rs2_data = ~dpat(tag);
    id_imm = 32'(tag) << 2; id_pc = 32'h100 + (32'(tag) << 2);
    ex_flush = fl; mem_stall = st;
  endtask

  task automatic ex(input logic pw, input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                    input logic rw, input logic mr, input logic [31:0] data,
                    input int lu, input int fl);
    exp_t e;
    e.pw = pw; e.v = v; e.rd = rd; e.rs1 = rs1; e.rw = rw; e.mr = mr;
    e.data = data; e.lu = lu; e.fl = fl;
    q.push_back(e);
  endtask

  // Monitor: pc_write is sampled mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      pw_s = pc_write;
      ifw_s = if_id_write;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_write", 32'(pw_s), 32'(e.pw));
        chk("if_id_write", 32'(ifw_s), 32'(e.pw));
        chk("id_ex_valid", 32'(id_ex_valid), 32'(e.v));
        chk("id_ex_rd", 32'(id_ex_rd), 32'(e.rd));
        chk("id_ex_rs1", 32'(id_ex_rs1), 32'(e.rs1));
        chk("id_ex_reg_write", 32'(id_ex_reg_write), 32'(e.rw));
        chk("id_ex_mem_read", 32'(id_ex_mem_read), 32'(e.mr));
        chk("id_ex_mem_write", 32'(id_ex_mem_write), 32'd0);
        chk("id_ex_rs1_data", id_ex_rs1_data, e.data);
        chk("load_use_cnt", 32'(load_use_cnt), 32'(e.lu));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.fl));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(id_ex_valid), 32'd0);
    chk({tag, "_rd"}, 32'(id_ex_rd), 32'd0);
    chk({tag, "_rs1"}, 32'(id_ex_rs1), 32'd0);
    chk({tag, "_reg_write"}, 32'(id_ex_reg_write), 32'd0);
    chk({tag, "_mem_read"}, 32'(id_ex_mem_read), 32'd0);
    chk({tag, "_rs1_data"}, id_ex_rs1_data, 32'd0);
    chk({tag, "_imm"}, id_ex_imm, 32'd0);
    chk({tag, "_load_use_cnt"}, 32'(load_use_cnt), 32'd0);
    chk({tag, "_flush_cnt"}, 32'(flush_cnt), 32'd0);
    chk({tag, "_pc_write"}, 32'(pc_write), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0; id_alu_op = 0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; id_branch = 0; ex_flush = 0; mem_stall = 0;
    @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //   v rs1 rs2 rd u1 u2 mr rw fl st tag        pw v rd rs1 rw mr data lu fl
    drv(1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 1);   ex(1, 1, 5, 1, 1, 1, dpat(1), 0, 0);
    drv(1, 5, 0, 6, 1, 0, 0, 1, 0, 0, 2);   ex(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 5, 0, 6, 1, 0, 0, 1, 0, 0, 3);   ex(1, 1, 6, 5, 1, 0, dpat(3), 1, 0);
    drv(1, 2, 0, 0, 1, 0, 1, 1, 0, 0, 4);   ex(1, 1, 0, 2, 1, 1, dpat(4), 1, 0);
    drv(1, 0, 0, 7, 1, 0, 0, 1, 0, 0, 5);   ex(1, 1, 7, 0, 1, 0, dpat(5), 1, 0);
    drv(1, 3, 0, 5, 1, 0, 1, 1, 0, 0, 6);   ex(1, 1, 5, 3, 1, 1, dpat(6), 1, 0);
    drv(1, 4, 5, 8, 1, 0, 0, 1, 0, 0, 7);   ex(1, 1, 8, 4, 1, 0, dpat(7), 1, 0);
    drv(1, 3, 0, 5, 1, 0, 1, 1, 0, 0, 8);   ex(1, 1, 5, 3, 1, 1, dpat(8), 1, 0);
    drv(1, 5, 0, 6, 1, 0, 0, 1, 1, 0, 9);   ex(1, 0, 0, 0, 0, 0, 0, 1, 1);
    // back-to-back dependent loads: one bubble per pair
    drv(1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 10);  ex(1, 1, 5, 1, 1, 1, dpat(10), 1, 1);
    drv(1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 11);  ex(0, 0, 0, 0, 0, 0, 0, 2, 1);
    drv(1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 12);  ex(1, 1, 6, 5, 1, 1, dpat(12), 2, 1);
    drv(1, 6, 0, 7, 1, 0, 0, 1, 0, 0, 13);  ex(0, 0, 0, 0, 0, 0, 0, 3, 1);
    drv(1, 6, 0, 7, 1, 0, 0, 1, 0, 0, 14);  ex(1, 1, 7, 6, 1, 0, dpat(14), 3, 1);
    for (int i = 0; i < 3; i++) begin
      drv(1, 7, 0, 9, 1, 0, 0, 1, 1, 1, 15 + i);
      ex(0, 1, 7, 6, 1, 0, dpat(14), 3, 1);
    end
    drv(1, 7, 0, 9, 1, 0, 0, 1, 1, 0, 18);  ex(1, 0, 0, 0, 0, 0, 0, 3, 2);
    drv(0, 2, 0, 9, 1, 0, 1, 1, 0, 0, 19);  ex(1, 0, 9, 2, 0, 0, dpat(19), 3, 2);
    drv(1, 2, 0, 10, 1, 0, 0, 1, 0, 0, 20); ex(1, 1, 10, 2, 1, 0, dpat(20), 3, 2);

    @(negedge clk);
    id_valid = 1; id_reg_write = 1; mem_stall = 1; ex_flush = 1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1; mem_stall = 0; ex_flush = 0; id_valid = 0; id_mem_read = 0;

    drv(1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 21);  ex(1, 1, 5, 1, 1, 1, dpat(21), 0, 0);
    drv(1, 5, 0, 6, 1, 0, 0, 1, 1, 0, 22);  ex(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      drv(1, 5, 0, 6, 1, 0, 0, 1, 1, 0, 30 + i);
      ex(1, 0, 0, 0, 0, 0, 0, 0, (i + 2 > 15) ? 15 : i + 2);
    end

    @(negedge clk);
    ex_flush = 0; id_valid = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
